// File: rtl/dma_pack_fifo_pkg.sv
// Shared types and helpers for the DMA pack FIFO: transfer size and write-ceiling
// codes, plus their byte-count decoders.
package dma_fifo_pkg;

    typedef enum logic [1:0] {B1, B2, B4, B8} size_code_e;
    typedef enum logic [1:0] {QUARTER, HALF, THREE_QUARTER, FULL} thresh_e;

    function automatic logic [3:0] size_bytes(size_code_e code);
        case (code)
            B1:      return 4'd1;
            B2:      return 4'd2;
            B4:      return 4'd4;
            B8:      return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Ceiling in bytes: (t+1)/4 of a 2^size_exp byte buffer.
    function automatic int unsigned thresh_bytes(thresh_e t, int unsigned size_exp);
        return ((32'(t) + 32'd1) << size_exp) >> 2;
    endfunction

endpackage

// File: rtl/dma_pack_fifo_if.sv
// Request/response bundle of the DMA pack FIFO; master drives requests, slave is the FIFO.
interface dma_pack_fifo_if #(
    parameter int unsigned WBUS     = 32,
    parameter int unsigned SIZE_EXP = 5
);
    localparam int unsigned NB = WBUS / 8;

    logic                i_clear;
    logic                i_put;
    logic [1:0]          i_put_size;
    logic [WBUS-1:0]     i_wdata;
    logic                i_pull;
    logic [1:0]          i_pull_size;
    logic                i_drain;
    logic [1:0]          i_filling_thresh;
    logic [WBUS-1:0]     o_rdata;
    logic [NB-1:0]       o_rstrb;
    logic                o_put_ok;
    logic                o_pull_ok;
    logic                o_overrun;
    logic                o_underrun;
    logic                o_size_err;
    logic                o_empty;
    logic                o_full;
    logic [1:0]          o_fullness;
    logic [SIZE_EXP:0]   o_left_put;
    logic [SIZE_EXP:0]   o_left_pull;

    modport master (
        output i_clear, i_put, i_put_size, i_wdata, i_pull, i_pull_size, i_drain,
               i_filling_thresh,
        input  o_rdata, o_rstrb, o_put_ok, o_pull_ok, o_overrun, o_underrun, o_size_err,
               o_empty, o_full, o_fullness, o_left_put, o_left_pull
    );

    modport slave (
        input  i_clear, i_put, i_put_size, i_wdata, i_pull, i_pull_size, i_drain,
               i_filling_thresh,
        output o_rdata, o_rstrb, o_put_ok, o_pull_ok, o_overrun, o_underrun, o_size_err,
               o_empty, o_full, o_fullness, o_left_put, o_left_pull
    );

endinterface

// File: rtl/dma_pack_fifo_byte_rot.sv
// NB-lane byte barrel rotator, lane index taken modulo NB.
// LEFT=1: out lane k+amt <- in lane k; LEFT=0: out lane k <- in lane k+amt.
module dma_byte_rot #(
    parameter int unsigned NB   = 4,
    parameter bit          LEFT = 1'b0
) (
    input  logic [NB*8-1:0]         data_i,
    input  logic [$clog2(NB)-1:0]   amt_i,
    output logic [NB*8-1:0]         data_o
);
    localparam int unsigned NB_EXP = $clog2(NB);

    logic [NB_EXP-1:0] src;

    always_comb begin
        data_o = '0;
        src    = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            src = LEFT ? NB_EXP'(k) - amt_i : NB_EXP'(k) + amt_i;
            data_o[k*8 +: 8] = data_i[src*8 +: 8];
        end
    end

endmodule

// File: rtl/dma_pack_fifo.sv
// DMA channel byte FIFO packing 1/2/4/8-byte puts and pulls into a circular buffer.
// Optional partial (drain) pulls are enabled with DMA_PACK_FIFO_DRAIN_EN.
module dma_pack_fifo
    import dma_fifo_pkg::*;
#(
    parameter int unsigned SIZE_EXP = 5,
    parameter int unsigned WBUS     = 32
) (
    input  logic           i_clk,
    input  logic           i_nreset,
    dma_pack_fifo_if.slave bus
);
    localparam int unsigned NB     = WBUS / 8;
    localparam int unsigned NB_EXP = $clog2(NB);
    localparam int unsigned DEPTH  = 1 << SIZE_EXP;
    localparam int unsigned ROW_W  = SIZE_EXP - NB_EXP;
    localparam int unsigned ROWS   = 1 << ROW_W;

    typedef logic [SIZE_EXP:0] cnt_t;

    logic [SIZE_EXP-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t                count_q, count_d;
    // Buffer is banked by lane so one row access per bank serves any unaligned transfer.
    logic [7:0]          mem_q [ROWS][NB];

    size_code_e put_code, pull_code;
    logic       put_legal, pull_legal, put_fit, pull_avail, drain;
    logic [3:0] nput, npull, ntake;
    cnt_t       border;

    assign put_code   = size_code_e'(bus.i_put_size);
    assign pull_code  = size_code_e'(bus.i_pull_size);
    assign put_legal  = !(WBUS == 32 && put_code == B8);
    assign pull_legal = !(WBUS == 32 && pull_code == B8);
    assign nput       = put_legal  ? size_bytes(put_code)  : 4'd0;
    assign npull      = pull_legal ? size_bytes(pull_code) : 4'd0;
    assign border     = cnt_t'(thresh_bytes(thresh_e'(bus.i_filling_thresh), SIZE_EXP));
    assign put_fit    = ((SIZE_EXP+2)'(count_q) + (SIZE_EXP+2)'(nput)) <= (SIZE_EXP+2)'(border);

`ifdef DMA_PACK_FIFO_DRAIN_EN
    assign drain = bus.i_drain;
`else
    logic drain_unused;
    assign drain_unused = bus.i_drain;
    assign drain        = 1'b0;
`endif

    always_comb begin
        if (drain) begin
            pull_avail = (count_q != '0);
            ntake      = (count_q < cnt_t'(npull)) ? count_q[3:0] : npull;
        end else begin
            pull_avail = (count_q >= cnt_t'(npull));
            ntake      = npull;
        end
    end

    assign bus.o_put_ok   = bus.i_put  && put_legal  && put_fit    && !bus.i_clear;
    assign bus.o_overrun  = bus.i_put  && put_legal  && !put_fit   && !bus.i_clear;
    assign bus.o_pull_ok  = bus.i_pull && pull_legal && pull_avail && !bus.i_clear;
    assign bus.o_underrun = bus.i_pull && pull_legal && !pull_avail && !bus.i_clear;
    assign bus.o_size_err = (bus.i_put && !put_legal) || (bus.i_pull && !pull_legal);

    // Write scatter: rotate write lanes onto banks, bump row where the transfer wraps a row.
    logic [WBUS-1:0]  wdata_rot;
    logic [ROW_W-1:0] wr_row [NB];
    logic             wr_en  [NB];
    logic [NB_EXP-1:0] wr_off;

    dma_byte_rot #(.NB(NB), .LEFT(1'b1)) u_wr_rot (
        .data_i (bus.i_wdata),
        .amt_i  (wr_ptr_q[NB_EXP-1:0]),
        .data_o (wdata_rot)
    );

    always_comb begin
        wr_row = '{default: '0};
        wr_en  = '{default: 1'b0};
        wr_off = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            wr_off    = NB_EXP'(j) - wr_ptr_q[NB_EXP-1:0];
            wr_row[j] = wr_ptr_q[SIZE_EXP-1:NB_EXP] + ROW_W'(NB_EXP'(j) < wr_ptr_q[NB_EXP-1:0]);
            wr_en[j]  = bus.o_put_ok && (4'(wr_off) < nput);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned j = 0; j < NB; j++) begin
            if (wr_en[j]) mem_q[wr_row[j]][j] <= wdata_rot[j*8 +: 8];
        end
    end

    // Read gather: fetch one byte per bank, rotate back to LSB-aligned lane order.
    logic [WBUS-1:0]  rbank, rgather, rmask;
    logic [ROW_W-1:0] rd_row;

    always_comb begin
        rbank  = '0;
        rd_row = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            rd_row = rd_ptr_q[SIZE_EXP-1:NB_EXP] + ROW_W'(NB_EXP'(j) < rd_ptr_q[NB_EXP-1:0]);
            rbank[j*8 +: 8] = mem_q[rd_row][j];
        end
    end

    dma_byte_rot #(.NB(NB), .LEFT(1'b0)) u_rd_rot (
        .data_i (rbank),
        .amt_i  (rd_ptr_q[NB_EXP-1:0]),
        .data_o (rgather)
    );

    always_comb begin
        bus.o_rstrb = '0;
        rmask       = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            bus.o_rstrb[k]  = bus.o_pull_ok && (k < 32'(ntake));
            rmask[k*8 +: 8] = {8{bus.o_rstrb[k]}};
        end
    end

    assign bus.o_rdata = rgather & rmask;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (bus.o_put_ok)  wr_ptr_d = wr_ptr_q + SIZE_EXP'(nput);
            if (bus.o_pull_ok) rd_ptr_d = rd_ptr_q + SIZE_EXP'(ntake);
            count_d = count_q + (bus.o_put_ok  ? cnt_t'(nput)  : '0)
                              - (bus.o_pull_ok ? cnt_t'(ntake) : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.o_empty     = (count_q == '0);
    assign bus.o_full      = (count_q == cnt_t'(DEPTH));
    assign bus.o_fullness  = (count_q >= cnt_t'(3 * DEPTH / 4)) ? 2'd3 :
                             (count_q >= cnt_t'(DEPTH / 2))     ? 2'd2 :
                             (count_q >= cnt_t'(DEPTH / 4))     ? 2'd1 : 2'd0;
    assign bus.o_left_put  = (border > count_q) ? border - count_q : '0;
    assign bus.o_left_pull = count_q;

endmodule

// File: tb/tb_dma_pack_fifo.sv
// Directed self-checking bench for dma_pack_fifo (64-bit main instance, 32-bit size check).
module tb_dma_pack_fifo;
    logic i_clk = 1'b0;
    logic i_nreset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 i_clk = ~i_clk;

    dma_pack_fifo_if #(.WBUS(64), .SIZE_EXP(5)) bus64 ();
    dma_pack_fifo_if #(.WBUS(32), .SIZE_EXP(5)) bus32 ();

    dma_pack_fifo #(.SIZE_EXP(5), .WBUS(64)) u_dut (
        .i_clk    (i_clk),
        .i_nreset (i_nreset),
        .bus      (bus64)
    );

    dma_pack_fifo #(.SIZE_EXP(5), .WBUS(32)) u_dut32 (
        .i_clk    (i_clk),
        .i_nreset (i_nreset),
        .bus      (bus32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus64.i_put   = 1'b0;
        bus64.i_pull  = 1'b0;
        bus64.i_clear = 1'b0;
        bus64.i_drain = 1'b0;
    endtask

    task automatic put64(input logic [1:0] sz, input logic [63:0] d);
        bus64.i_put      = 1'b1;
        bus64.i_put_size = sz;
        bus64.i_wdata    = d;
        tick();
        bus64.i_put      = 1'b0;
    endtask

    task automatic clear64();
        bus64.i_clear = 1'b1;
        tick();
        bus64.i_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes_exp [4];
        bytes_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

        bus64.i_clear = 0; bus64.i_put = 0; bus64.i_put_size = 0; bus64.i_wdata = '0;
        bus64.i_pull = 0; bus64.i_pull_size = 0; bus64.i_drain = 0; bus64.i_filling_thresh = 2'd3;
        bus32.i_clear = 0; bus32.i_put = 0; bus32.i_put_size = 0; bus32.i_wdata = '0;
        bus32.i_pull = 0; bus32.i_pull_size = 0; bus32.i_drain = 0; bus32.i_filling_thresh = 2'd3;

        tick(); tick();
        i_nreset = 1'b1;
        tick();

        // Reset state
        chk("rst_empty", bus64.o_empty, 1);
        chk("rst_full", bus64.o_full, 0);
        chk("rst_fullness", bus64.o_fullness, 0);
        chk("rst_left_put", bus64.o_left_put, 32);
        chk("rst_left_pull", bus64.o_left_pull, 0);
        chk("rst_rdata", bus64.o_rdata, 0);
        chk("rst_rstrb", bus64.o_rstrb, 0);

        // Byte order
        bus64.i_put = 1; bus64.i_put_size = 2'd2; bus64.i_wdata = 64'h44332211;
        #1 chk("bo_put_ok", bus64.o_put_ok, 1);
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            bus64.i_pull = 1; bus64.i_pull_size = 2'd0;
            #1 chk("bo_rdata", bus64.o_rdata, {56'h0, bytes_exp[i]});
            tick(); idle();
        end
        chk("bo_empty", bus64.o_empty, 1);

        // Wrap-around: byte at address a holds a
        clear64();
        put64(2'd3, 64'h0706050403020100);
        put64(2'd3, 64'h0F0E0D0C0B0A0908);
        put64(2'd3, 64'h1716151413121110);
        put64(2'd2, 64'h1B1A1918);
        put64(2'd1, 64'h1D1C);
        chk("wr_count30", bus64.o_left_pull, 30);
        bus64.i_pull = 1; bus64.i_pull_size = 2'd3;
        #1 chk("wr_pull8_a", bus64.o_rdata, 64'h0706050403020100);
        tick(); tick(); tick();
        bus64.i_pull_size = 2'd2;
        #1 chk("wr_pull4", bus64.o_rdata, 64'h1B1A1918);
        tick(); idle();
        put64(2'd3, 64'h8877665544332211);
        bus64.i_pull = 1; bus64.i_pull_size = 2'd1;
        #1 chk("wr_pull2", bus64.o_rdata, 64'h1D1C);
        tick();
        chk("wr_count8", bus64.o_left_pull, 8);
        bus64.i_pull_size = 2'd3;
        #1 chk("wr_pull8_wrap", bus64.o_rdata, 64'h8877665544332211);
        chk("wr_rstrb", bus64.o_rstrb, 8'hFF);
        tick(); idle();
        chk("wr_empty", bus64.o_empty, 1);

        // Threshold
        put64(2'd3, 64'h0);
        put64(2'd2, 64'h0);
        put64(2'd1, 64'h0);
        bus64.i_filling_thresh = 2'd1;
        bus64.i_put = 1; bus64.i_put_size = 2'd2;
        #1 chk("th_overrun", bus64.o_overrun, 1);
        chk("th_put_ok", bus64.o_put_ok, 0);
        chk("th_left_put2", bus64.o_left_put, 2);
        tick(); idle();
        chk("th_count14", bus64.o_left_pull, 14);
        put64(2'd1, 64'h0);
        chk("th_count16", bus64.o_left_pull, 16);
        chk("th_left_put0", bus64.o_left_put, 0);
        chk("th_fullness", bus64.o_fullness, 2);
        bus64.i_filling_thresh = 2'd0;
        #1 chk("th_left_put_sat", bus64.o_left_put, 0);

        // Clear beats a same-cycle put
        bus64.i_clear = 1; bus64.i_put = 1; bus64.i_put_size = 2'd0;
        #1 chk("clr_put_ok", bus64.o_put_ok, 0);
        tick(); idle();
        chk("clr_count", bus64.o_left_pull, 0);
        bus64.i_filling_thresh = 2'd3;

        // Full
        for (int i = 0; i < 4; i++) put64(2'd3, 64'h0);
        chk("full_flag", bus64.o_full, 1);
        chk("full_fullness", bus64.o_fullness, 3);
        chk("full_left_put", bus64.o_left_put, 0);
        bus64.i_put = 1; bus64.i_put_size = 2'd0;
        #1 chk("full_overrun", bus64.o_overrun, 1);
        tick(); idle();
        clear64();

        // Drain
        put64(2'd0, 64'hAA);
        put64(2'd0, 64'hBB);
        put64(2'd0, 64'hCC);
        bus64.i_pull = 1; bus64.i_pull_size = 2'd3; bus64.i_drain = 0;
        #1 chk("nd_underrun", bus64.o_underrun, 1);
        chk("nd_rstrb", bus64.o_rstrb, 0);
        chk("nd_rdata", bus64.o_rdata, 0);
        tick();
        chk("nd_count", bus64.o_left_pull, 3);
        bus64.i_drain = 1;
`ifdef DMA_PACK_FIFO_DRAIN_EN
        #1 chk("dr_rstrb", bus64.o_rstrb, 8'h07);
        chk("dr_rdata", bus64.o_rdata, 64'hCCBBAA);
        chk("dr_pull_ok", bus64.o_pull_ok, 1);
        tick(); idle();
        chk("dr_count", bus64.o_left_pull, 0);
`else
        #1 chk("dr_ignored_underrun", bus64.o_underrun, 1);
        chk("dr_ignored_rstrb", bus64.o_rstrb, 0);
        tick(); idle();
        chk("dr_ignored_count", bus64.o_left_pull, 3);
        clear64();
`endif

        // Simultaneous put and pull
        clear64();
        put64(2'd2, 64'hDDCCBBAA);
        bus64.i_put = 1; bus64.i_put_size = 2'd2; bus64.i_wdata = 64'h11223344;
        bus64.i_pull = 1; bus64.i_pull_size = 2'd2;
        #1 chk("sim_put_ok", bus64.o_put_ok, 1);
        chk("sim_pull_ok", bus64.o_pull_ok, 1);
        chk("sim_rdata", bus64.o_rdata, 64'hDDCCBBAA);
        tick(); idle();
        chk("sim_count", bus64.o_left_pull, 4);
        bus64.i_pull = 1; bus64.i_pull_size = 2'd2;
        #1 chk("sim_rdata2", bus64.o_rdata, 64'h11223344);
        tick(); idle();
        bus64.i_pull = 1; bus64.i_pull_size = 2'd0;
        #1 chk("empty_underrun", bus64.o_underrun, 1);
        tick(); idle();

        // Reset mid-transfer
        put64(2'd2, 64'h01020304);
        bus64.i_put = 1; bus64.i_put_size = 2'd1;
        #2 i_nreset = 1'b0;
        #1 chk("mid_rst_empty", bus64.o_empty, 1);
        chk("mid_rst_count", bus64.o_left_pull, 0);
        idle();
        tick();
        i_nreset = 1'b1;
        tick();
        chk("mid_rst_after", bus64.o_left_pull, 0);

        // 32-bit bus: 8-byte code is illegal
        bus32.i_put = 1; bus32.i_put_size = 2'd3; bus32.i_wdata = 32'h12345678;
        #1 chk("w32_size_err", bus32.o_size_err, 1);
        chk("w32_put_ok", bus32.o_put_ok, 0);
        chk("w32_overrun", bus32.o_overrun, 0);
        tick();
        chk("w32_count0", bus32.o_left_pull, 0);
        bus32.i_put_size = 2'd2;
        #1 chk("w32_put4_ok", bus32.o_put_ok, 1);
        tick();
        bus32.i_put = 0;
        chk("w32_count4", bus32.o_left_pull, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
